// File: rtl/key_collect_rr_pkg.sv
// ---------------------------------------------------------------------------
// accel_pkg
//   Shared helpers for the accelerator key-collection blocks:
//     clog2        - ceiling log2 usable in constant expressions
//     tag_width    - channel-tag width, never narrower than one bit
//     cnt_width    - occupancy-count width able to hold DEPTH itself
//     depth_ok     - FIFO depth legality (power of two, at least 2)
//     num_ch_ok    - channel-count legality (2..16)
// ---------------------------------------------------------------------------
package accel_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned tag_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned d);
    return clog2(d) + 1;
  endfunction

  function automatic bit depth_ok(input int unsigned d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

  function automatic bit num_ch_ok(input int unsigned n);
    return (n >= 2) && (n <= 16);
  endfunction

endpackage

// File: rtl/key_collect_rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with a rotating priority pointer. The first
//   requester at or after the pointer (wrapping modulo NUM_CH) wins.
//   After a grant to channel i the pointer moves to (i+1) mod NUM_CH;
//   without a grant it holds.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, pointer -> 0
//   clr        in   synchronous clear, pointer -> 0
//   req        in   [NUM_CH]  per-channel requests
//   enable     in   grant permitted this cycle
//   advance    in   a grant was issued this cycle; move the pointer
//   grant      out  [NUM_CH]  one-hot grant (combinational)
//   grant_idx  out  [IDX_W]   index of the winning requester
// ---------------------------------------------------------------------------
module rr_arbiter
  import accel_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned IDX_W  = tag_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [NUM_CH-1:0] req,
  input  logic              enable,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_sel;
  logic             w_found;

  // Walk the channels starting at the pointer; the extra sum bit lets the
  // wrap be done by subtraction, so NUM_CH need not be a power of two.
  always_comb begin
    w_sum   = '0;
    w_cand  = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(off);
      if (w_sum >= (IDX_W+1)'(NUM_CH)) w_sum = w_sum - (IDX_W+1)'(NUM_CH);
      w_cand = w_sum[IDX_W-1:0];
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (enable && w_found) grant[w_sel] = 1'b1;
    grant_idx = w_sel;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/key_collect_rr.sv
// ---------------------------------------------------------------------------
// key_collect_rr
//   Collects keys from NUM_CH search-unit channels through a round-robin
//   arbiter into a first-word-fall-through FIFO and presents each key with
//   its source-channel tag on a valid/ready output. Counts stalled cycles
//   (some request pending, none granted), saturating at 16'hFFFF.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   flush      in   clear FIFO and arbiter pointer (beats write and pop)
//   req        in   [NUM_CH]        per-channel write request
//   key_in     in   [NUM_CH*KEY_W]  channel c key at [c*KEY_W +: KEY_W]
//   grant      out  [NUM_CH]        one-hot write accepted, same cycle
//   key_out    out  [KEY_W]         head-of-FIFO key
//   tag_out    out  [TAG_W]         source channel of head entry
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer takes the head this cycle
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  [CNT_W]         occupancy
//   stall_cnt  out  [16]            saturating stall-cycle count
// ---------------------------------------------------------------------------
module key_collect_rr
  import accel_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned KEY_W  = 32,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned TAG_W  = tag_width(NUM_CH),
  localparam int unsigned CNT_W  = cnt_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*KEY_W-1:0] key_in,
  output logic [NUM_CH-1:0]       grant,
  output logic [KEY_W-1:0]        key_out,
  output logic [TAG_W-1:0]        tag_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    full,
  output logic                    empty,
  output logic [CNT_W-1:0]        count,
  output logic [15:0]             stall_cnt
);

  localparam int unsigned AW = clog2(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("key_collect_rr: DEPTH must be a power of two and at least 2");
  end
  if (!num_ch_ok(NUM_CH)) begin : g_bad_num_ch
    $error("key_collect_rr: NUM_CH must be in 2..16");
  end

  logic [KEY_W-1:0]  r_key_mem [DEPTH];
  logic [TAG_W-1:0]  r_tag_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [15:0]       r_stall;

  logic              w_pop;
  logic              w_space;
  logic              w_arb_en;
  logic              w_wr;
  logic [NUM_CH-1:0] w_grant;
  logic [TAG_W-1:0]  w_gidx;
  logic [KEY_W-1:0]  w_key;

  assign out_valid = (r_count != '0);
  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign stall_cnt = r_stall;
  assign key_out   = r_key_mem[r_rd_ptr];
  assign tag_out   = r_tag_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_pop    = out_valid & out_ready;
  assign w_space  = !full | w_pop;
  assign w_arb_en = w_space & !flush & !rst;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .req       (req),
    .enable    (w_arb_en),
    .advance   (w_wr),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  assign grant = w_grant;
  assign w_wr  = |w_grant;

  always_comb begin
    w_key = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_gidx == TAG_W'(c)) w_key = key_in[c*KEY_W +: KEY_W];
    end
  end

  // Storage has no reset; visibility is governed entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_key_mem[r_wr_ptr] <= w_key;
      r_tag_mem[r_wr_ptr] <= w_gidx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Flush holds the stall count and its cycle is never counted as a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (!flush && (|req) && !w_wr && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

endmodule
